// File: rtl/dualrail_chan_sink_pkg.sv
// Shared types and constants for the dual-rail channel sink: FSM states,
// rail-pair encodings and a constant-evaluable clog2.
package dualrail_pkg;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_ACK   = 2'd1,
        ST_STALL = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    // Rail pair is {d1, d0}
    localparam logic [1:0] NEUTRAL = 2'b00;
    localparam logic [1:0] ZERO    = 2'b01;
    localparam logic [1:0] ONE     = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) r++;
        return r;
    endfunction

endpackage

// File: rtl/dualrail_chan_sink_if.sv
// Bundle of the channel rails and the word stream around the sink.
interface dualrail_chan_sink_if #(
    parameter int unsigned WORD_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) ();
    logic                                        d0;
    logic                                        d1;
    logic                                        e;
    logic [WORD_BITS-1:0]                        word;
    logic                                        word_valid;
    logic                                        word_ready;
    logic [dualrail_pkg::clog2(FIFO_DEPTH):0]    fifo_count;
    logic                                        rail_err;

    // Channel source and word consumer side
    modport master (
        output d0, d1, word_ready,
        input  e, word, word_valid, fifo_count, rail_err
    );

    // Sink side
    modport slave (
        input  d0, d1, word_ready,
        output e, word, word_valid, fifo_count, rail_err
    );
endinterface

// File: rtl/dualrail_chan_sink_sync_fifo.sv
// Circular word buffer with a registered head-of-queue output so the
// presented word never glitches while it waits for the consumer.
module sync_fifo
    import dualrail_pkg::*;
#(
    parameter int unsigned WORD_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push_i,
    input  logic [WORD_BITS-1:0]          data_i,
    input  logic                          pop_i,
    output logic [WORD_BITS-1:0]          data_o,
    output logic [clog2(FIFO_DEPTH):0]    count_o,
    output logic                          full_o,
    output logic                          empty_o
);
    localparam int unsigned PTR_W = clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WORD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WORD_BITS-1:0] head_q, head_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 do_pop_c, do_push_c;
    logic [PTR_W-1:0]     rd_next_c;

    always_comb begin
        do_pop_c  = pop_i & ~empty_q;
        do_push_c = push_i & (~full_q | do_pop_c);
        rd_next_c = rd_ptr_q + PTR_W'(1);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        head_d    = head_q;

        if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop_c)  rd_ptr_d = rd_next_c;

        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Head follows the next read pointer; bypass when the new head is being written now
        if (do_pop_c) begin
            head_d = (do_push_c && (wr_ptr_q == rd_next_c)) ? data_i : mem_q[rd_next_c];
        end else if (do_push_c && empty_q) begin
            head_d = data_i;
        end

        full_d  = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = head_q;
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/dualrail_chan_sink.sv
// Clocked sink for a four-phase 1-of-2 dual-rail channel: synchronizes the
// rails, assembles tokens LSB-first into words and buffers them for a stream.
module dualrail_chan_sink
    import dualrail_pkg::*;
#(
    parameter int unsigned WORD_BITS   = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          d0_i,
    input  logic                          d1_i,
    output logic                          e_o,
    output logic [WORD_BITS-1:0]          word_o,
    output logic                          word_valid_o,
    input  logic                          word_ready_i,
    output logic [clog2(FIFO_DEPTH):0]    fifo_count_o,
    output logic                          rail_err_o
);
    localparam int unsigned BIT_W = (WORD_BITS > 1) ? clog2(WORD_BITS) : 1;

    logic [SYNC_STAGES-1:0] d0_sync_q, d1_sync_q;
    logic                   d0_s, d1_s;
    logic [1:0]             rails_c;

    state_e                 state_q;
    logic [BIT_W-1:0]       bitcnt_q;
    logic [WORD_BITS-1:0]   shreg_q;
    logic                   e_q;
    logic                   rail_err_q;

    logic                   fifo_full, fifo_empty;
    logic                   pop_c, push_c, can_push_c, word_last_c;

    // Rails are asynchronous; only the last synchronizer stage feeds the FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            d0_sync_q <= '0;
            d1_sync_q <= '0;
        end else begin
            d0_sync_q <= {d0_sync_q[SYNC_STAGES-2:0], d0_i};
            d1_sync_q <= {d1_sync_q[SYNC_STAGES-2:0], d1_i};
        end
    end

    assign d0_s    = d0_sync_q[SYNC_STAGES-1];
    assign d1_s    = d1_sync_q[SYNC_STAGES-1];
    assign rails_c = {d1_s, d0_s};

    always_comb begin
        pop_c       = word_ready_i & ~fifo_empty;
        can_push_c  = ~fifo_full | pop_c;
        word_last_c = (bitcnt_q == BIT_W'(WORD_BITS - 1));
        push_c      = 1'b0;
        case (state_q)
            ST_ACK:   push_c = (rails_c == NEUTRAL) && word_last_c && can_push_c;
            ST_STALL: push_c = can_push_c;
            default:  push_c = 1'b0;
        endcase
    end

    // Enable is only re-raised once the token just acknowledged has a home
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_READY;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            e_q        <= 1'b1;
            rail_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_READY: begin
                    if (rails_c == ILLEGAL) begin
                        state_q    <= ST_ERR;
                        e_q        <= 1'b0;
                        rail_err_q <= 1'b1;
                    end else if (rails_c != NEUTRAL) begin
                        shreg_q[bitcnt_q] <= d1_s;
                        state_q           <= ST_ACK;
                        e_q               <= 1'b0;
                    end
                end
                ST_ACK: begin
                    if (rails_c == ILLEGAL) begin
                        state_q    <= ST_ERR;
                        rail_err_q <= 1'b1;
                    end else if (rails_c == NEUTRAL) begin
                        if (!word_last_c) begin
                            bitcnt_q <= bitcnt_q + BIT_W'(1);
                            state_q  <= ST_READY;
                            e_q      <= 1'b1;
                        end else if (push_c) begin
                            bitcnt_q <= '0;
                            state_q  <= ST_READY;
                            e_q      <= 1'b1;
                        end else begin
                            state_q  <= ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    if (push_c) begin
                        bitcnt_q <= '0;
                        state_q  <= ST_READY;
                        e_q      <= 1'b1;
                    end
                end
                ST_ERR: begin
                    e_q        <= 1'b0;
                    rail_err_q <= 1'b1;
                end
                default: state_q <= ST_READY;
            endcase
        end
    end

    sync_fifo #(
        .WORD_BITS  (WORD_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .data_i  (shreg_q),
        .pop_i   (pop_c),
        .data_o  (word_o),
        .count_o (fifo_count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign e_o          = e_q;
    assign rail_err_o   = rail_err_q;
    assign word_valid_o = ~fifo_empty;

endmodule

// File: tb/tb_dualrail_chan_sink.sv
// Directed bench for dualrail_chan_sink: acts as a four-phase dual-rail source
// and as the word consumer, checking outputs 1 time unit after each rising edge.
module tb_dualrail_chan_sink;
    logic clk;
    logic reset;

    int vectors     = 0;
    int miscompares = 0;

    dualrail_chan_sink_if #(.WORD_BITS(8), .FIFO_DEPTH(4)) bus ();

    dualrail_chan_sink #(
        .WORD_BITS   (8),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .d0_i         (bus.d0),
        .d1_i         (bus.d1),
        .e_o          (bus.e),
        .word_o       (bus.word),
        .word_valid_o (bus.word_valid),
        .word_ready_i (bus.word_ready),
        .fifo_count_o (bus.fifo_count),
        .rail_err_o   (bus.rail_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  sent [16];
    logic [7:0]  rx [$];
    int          max_count;
    int          mon_cyc;
    logic [31:0] got;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Bounded wait for the enable to reach a level
    task automatic wait_e(input logic v, input string tag);
        int n;
        n = 0;
        while (bus.e !== v && n < 100) begin
            tick(1);
            n++;
        end
        check(tag, 32'(bus.e), 32'(v));
    endtask

    task automatic send_token(input logic b);
        wait_e(1'b1, "tok_ready");
        if (b) bus.d1 = 1'b1;
        else   bus.d0 = 1'b1;
        wait_e(1'b0, "tok_ack");
        bus.d0 = 1'b0;
        bus.d1 = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_token(w[i]);
    endtask

    task automatic pop_one();
        bus.word_ready = 1'b1;
        tick(1);
        bus.word_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        bus.d0 = 1'b0;
        bus.d1 = 1'b0;
        bus.word_ready = 1'b0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;

        check("rst_e",     32'(bus.e),          32'd1);
        check("rst_valid", 32'(bus.word_valid), 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        check("rst_err",   32'(bus.rail_err),   32'd0);
        check("rst_word",  32'(bus.word),       32'd0);

        // Tokens 1,0,1,1,0,0,1,0 LSB-first form 8'h4D
        pat = 8'h4D;
        for (int i = 0; i < 7; i++) send_token(pat[i]);
        wait_e(1'b1, "t1_ready7");
        bus.d0 = 1'b1;
        wait_e(1'b0, "t1_ack7");
        bus.d0 = 1'b0;
        tick(2);
        check("t1_valid_early", 32'(bus.word_valid), 32'd0);
        tick(1);
        check("t1_valid", 32'(bus.word_valid), 32'd1);
        check("t1_word",  32'(bus.word),       32'h4D);
        check("t1_count", 32'(bus.fifo_count), 32'd1);
        check("t1_e",     32'(bus.e),          32'd1);
        pop_one();
        check("t1_pop_count", 32'(bus.fifo_count), 32'd0);
        check("t1_pop_valid", 32'(bus.word_valid), 32'd0);

        // Backpressure: five words into a four-deep buffer
        for (int w = 1; w <= 5; w++) send_word(8'(w));
        tick(6);
        check("stall_e",     32'(bus.e),          32'd0);
        check("stall_count", 32'(bus.fifo_count), 32'd4);
        check("stall_head",  32'(bus.word),       32'h01);
        pop_one();
        check("unstall_count", 32'(bus.fifo_count), 32'd4);
        check("unstall_e",     32'(bus.e),          32'd1);
        check("unstall_head",  32'(bus.word),       32'h02);
        for (int w = 2; w <= 5; w++) begin
            check($sformatf("drain_%0d", w), 32'(bus.word), 32'(w));
            pop_one();
        end
        check("drain_count", 32'(bus.fifo_count), 32'd0);
        check("drain_valid", 32'(bus.word_valid), 32'd0);

        // Illegal rail pair with words already buffered
        send_word(8'hA5);
        send_word(8'h3C);
        wait_e(1'b1, "err_pre_ready");
        check("err_pre_count", 32'(bus.fifo_count), 32'd2);
        bus.d0 = 1'b1;
        bus.d1 = 1'b1;
        tick(2);
        check("err_early",   32'(bus.rail_err), 32'd0);
        check("err_early_e", 32'(bus.e),        32'd1);
        tick(1);
        check("err_flag", 32'(bus.rail_err), 32'd1);
        check("err_e",    32'(bus.e),        32'd0);
        tick(10);
        bus.d0 = 1'b0;
        bus.d1 = 1'b0;
        tick(5);
        check("err_hold",   32'(bus.rail_err),   32'd1);
        check("err_hold_e", 32'(bus.e),          32'd0);
        check("err_count",  32'(bus.fifo_count), 32'd2);
        check("err_head0",  32'(bus.word),       32'hA5);
        pop_one();
        check("err_head1",  32'(bus.word),       32'h3C);
        check("err_count1", 32'(bus.fifo_count), 32'd1);
        pop_one();
        check("err_drained", 32'(bus.word_valid), 32'd0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("err_rst_flag",  32'(bus.rail_err),   32'd0);
        check("err_rst_e",     32'(bus.e),          32'd1);
        check("err_rst_count", 32'(bus.fifo_count), 32'd0);

        // Reset in the middle of a word leaves no residue
        for (int i = 0; i < 3; i++) send_token(1'b0);
        wait_e(1'b1, "mid_ready");
        bus.d0 = 1'b1;
        wait_e(1'b0, "mid_ack");
        reset = 1'b1;
        bus.d0 = 1'b0;
        tick(3);
        reset = 1'b0;
        check("mid_rst_count", 32'(bus.fifo_count), 32'd0);
        check("mid_rst_e",     32'(bus.e),          32'd1);
        send_word(8'hFF);
        wait_e(1'b1, "mid_done");
        check("mid_word",  32'(bus.word),       32'hFF);
        check("mid_count", 32'(bus.fifo_count), 32'd1);
        pop_one();

        // Pin-to-enable latency and no re-capture on a held rail
        bus.d1 = 1'b1;
        tick(2);
        check("lat_rise_early", 32'(bus.e), 32'd1);
        tick(1);
        check("lat_rise", 32'(bus.e), 32'd0);
        tick(10);
        check("lat_hold_e",     32'(bus.e),          32'd0);
        check("lat_hold_count", 32'(bus.fifo_count), 32'd0);
        bus.d1 = 1'b0;
        tick(2);
        check("lat_fall_early", 32'(bus.e), 32'd0);
        tick(1);
        check("lat_fall", 32'(bus.e), 32'd1);
        for (int i = 0; i < 7; i++) send_token(1'b0);
        wait_e(1'b1, "lat_done");
        check("lat_word",  32'(bus.word),       32'h01);
        check("lat_count", 32'(bus.fifo_count), 32'd1);
        pop_one();

        // Continuous stream with the consumer always ready
        for (int i = 0; i < 16; i++) sent[i] = 8'($urandom);
        max_count = 0;
        mon_cyc = 0;
        bus.word_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 16; i++) send_word(sent[i]);
            end
            begin
                while (rx.size() < 16 && mon_cyc < 4000) begin
                    @(posedge clk);
                    #1;
                    mon_cyc++;
                    if (bus.word_valid === 1'b1) rx.push_back(bus.word);
                    if (int'(bus.fifo_count) > max_count) max_count = int'(bus.fifo_count);
                end
            end
        join
        bus.word_ready = 1'b0;
        check("stream_n",   32'(rx.size()), 32'd16);
        check("stream_max", 32'(max_count), 32'd1);
        for (int i = 0; i < 16; i++) begin
            got = (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD;
            check($sformatf("stream_%0d", i), got, 32'(sent[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
